// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the digit-scan controller.
//   SEL_W   : width of the digit index driven to the 3-to-8 decoder
//   MASK_W  : width of the per-digit suppress mask
//   state_t : controller states (IDLE / ON / BLANK)
package scan_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned MASK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Scan control bus between the integrating wrapper and digit_scan_ctrl.
//   run        : scan enable (wrapper -> controller)
//   mask       : per-digit suppress bits (wrapper -> controller)
//   sel        : digit index to the decoder
//   sel_en     : decoder enable
//   slot_start : one-cycle pulse on the first ON cycle of each slot
//   frame_done : one-cycle pulse on the first ON cycle of slot 0 after a wrap
interface digit_scan_ctrl_if;
  import scan_pkg::*;

  logic              run;
  logic [MASK_W-1:0] mask;
  logic [SEL_W-1:0]  sel;
  logic              sel_en;
  logic              slot_start;
  logic              frame_done;

  modport master (
    output run, mask,
    input  sel, sel_en, slot_start, frame_done
  );

  modport slave (
    input  run, mask,
    output sel, sel_en, slot_start, frame_done
  );

endinterface

// File: rtl/scan_prescaler.sv
// Modulo-CLK_DIV slot counter with synchronous clear and a programmable
// terminal compare.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0 (has priority over counting)
//   cmp        : compare value; tc is high while the count equals it
//   tc         : terminal-count flag
module scan_prescaler #(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] cmp,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Counter wraps at CLK_DIV-1 regardless of the compare value, so the
  // ON->BLANK transition keeps counting into the blank window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(CLK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == cmp);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit-scan controller feeding a 3-to-8 enable decoder.
// Steps sel through DIGITS slots of CLK_DIV cycles each, holding the
// decoder enable low for BLANK_CYC cycles at the end of each slot.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of digit_scan_ctrl_if (run/mask in,
//                sel/sel_en/slot_start/frame_done out)
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  digit_scan_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W     = $clog2(CLK_DIV);
  localparam bit          HAS_BLANK = (BLANK_CYC != 0);

  // Elaboration-time parameter range checks.
  if (CLK_DIV < 2 || CLK_DIV > (1 << 20)) begin : g_bad_clk_div
    $error("digit_scan_ctrl: CLK_DIV out of range 2..2^20");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("digit_scan_ctrl: DIGITS out of range 1..8");
  end
  if (BLANK_CYC > CLK_DIV - 1) begin : g_bad_blank
    $error("digit_scan_ctrl: BLANK_CYC must be at most CLK_DIV-1");
  end

  state_t           state;
  logic [SEL_W-1:0] sel_q;
  logic             slot_start_q;
  logic             frame_done_q;

  logic             tc;
  logic             pre_clr;
  logic [CNT_W-1:0] pre_cmp;
  logic             sel_wrap;
  logic [SEL_W-1:0] sel_next;

  // Counter held at 0 while idle or when run is dropped.
  assign pre_clr = (state == ST_IDLE) || !bus.run;
  // ON ends at CLK_DIV-BLANK_CYC-1; BLANK ends at the slot end.
  assign pre_cmp = (state == ST_BLANK) ? CNT_W'(CLK_DIV - 1)
                                       : CNT_W'(CLK_DIV - BLANK_CYC - 1);

  scan_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pre_clr),
    .cmp   (pre_cmp),
    .tc    (tc)
  );

  assign sel_wrap = (sel_q == SEL_W'(DIGITS - 1));
  assign sel_next = sel_wrap ? '0 : sel_q + SEL_W'(1);

  // Scan FSM with registered index and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sel_q        <= '0;
      slot_start_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      slot_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      if (!bus.run) begin
        state <= ST_IDLE;
        sel_q <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            state        <= ST_ON;
            sel_q        <= '0;
            slot_start_q <= 1'b1;
          end
          ST_ON: begin
            if (tc) begin
              if (HAS_BLANK) begin
                state <= ST_BLANK;
              end else begin
                sel_q        <= sel_next;
                slot_start_q <= 1'b1;
                frame_done_q <= sel_wrap;
              end
            end
          end
          ST_BLANK: begin
            if (tc) begin
              state        <= ST_ON;
              sel_q        <= sel_next;
              slot_start_q <= 1'b1;
              frame_done_q <= sel_wrap;
            end
          end
          default: begin
            state <= ST_IDLE;
            sel_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.sel        = sel_q;
  // Enable is decoded straight from state and mask so mask edits act at once.
  assign bus.sel_en     = (state == ST_ON) && !bus.mask[sel_q];
  assign bus.slot_start = slot_start_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: two instances
//   dut_a : CLK_DIV=4, BLANK_CYC=1, DIGITS=5 (start, wrap, mask, stop, reset)
//   dut_b : CLK_DIV=3, BLANK_CYC=0, DIGITS=8 (no dead time)
module tb_digit_scan_ctrl;

  logic clk;
  logic rst_n;

  digit_scan_ctrl_if bus_a ();
  digit_scan_ctrl_if bus_b ();

  digit_scan_ctrl #(.CLK_DIV(4), .DIGITS(5), .BLANK_CYC(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  digit_scan_ctrl #(.CLK_DIV(3), .DIGITS(8), .BLANK_CYC(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // {sel, sel_en, slot_start, frame_done}
  function automatic logic [5:0] obs_a();
    return {bus_a.sel, bus_a.sel_en, bus_a.slot_start, bus_a.frame_done};
  endfunction

  function automatic logic [5:0] obs_b();
    return {bus_b.sel, bus_b.sel_en, bus_b.slot_start, bus_b.frame_done};
  endfunction

  // Expected outputs t cycles after run was sampled: 4-cycle slots
  // (3 ON + 1 BLANK), five digits per frame.
  function automatic logic [5:0] exp_a(input int t, input logic [7:0] m);
    int pos;
    int slot;
    logic [2:0] s;
    logic en, ss, fd;
    pos  = t % 4;
    slot = t / 4;
    s    = 3'(slot % 5);
    en   = (pos < 3) && !m[s];
    ss   = (pos == 0);
    fd   = (pos == 0) && (slot > 0) && (slot % 5 == 0);
    return {s, en, ss, fd};
  endfunction

  // 3-cycle slots, no blank, eight digits per frame.
  function automatic logic [5:0] exp_b(input int t);
    int slot;
    logic [2:0] s;
    logic ss, fd;
    slot = t / 3;
    s    = 3'(slot % 8);
    ss   = (t % 3 == 0);
    fd   = ss && (slot > 0) && (slot % 8 == 0);
    return {s, 1'b1, ss, fd};
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed {sel,en,ss,fd}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (input-drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] m;
    rst_n      = 1'b0;
    bus_a.run  = 1'b0;
    bus_a.mask = 8'h00;
    bus_b.run  = 1'b0;
    bus_b.mask = 8'h00;

    // Reset state.
    #2;
    check("reset_a", obs_a(), 6'b000_000);
    check("reset_b", obs_b(), 6'b000_000);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after release: nothing happens without run.
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check($sformatf("idle_a[%0d]", i), obs_a(), 6'b000_000);
      check($sformatf("idle_b[%0d]", i), obs_b(), 6'b000_000);
    end

    // Start, wrap, mask and mid-slot mask flip; run drops in BLANK of slot 3.
    step();
    bus_a.run = 1'b1;
    #1;
    check("pre_start_a", obs_a(), 6'b000_000);
    for (int n = 0; n < 56; n++) begin
      step();
      m = (n >= 24) ? 8'h04 : 8'h00;
      if (n == 25) m = m | 8'h02;
      bus_a.mask = m;
      bus_a.run  = (n == 55) ? 1'b0 : 1'b1;
      #1;
      check($sformatf("scan_a[%0d]", n), obs_a(), exp_a(n, m));
    end

    // One IDLE cycle, then run re-raised.
    step();
    bus_a.run = 1'b1;
    #1;
    check("stop_idle_a", obs_a(), 6'b000_000);

    // Restart from slot 0 with a full ON window and no frame_done.
    for (int t = 0; t < 12; t++) begin
      step();
      #1;
      check($sformatf("restart_a[%0d]", t), obs_a(), exp_a(t, 8'h04));
    end

    // Async reset during ON: slot 3 first cycle, then reset between edges.
    step();
    #1;
    check("pre_rst_a", obs_a(), 6'b011_110);
    rst_n = 1'b0;
    #1;
    check("async_rst_a", obs_a(), 6'b000_000);
    bus_a.run = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check($sformatf("post_rst_idle_a[%0d]", i), obs_a(), 6'b000_000);
    end
    step();
    bus_a.mask = 8'h00;
    bus_a.run  = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step();
      #1;
      check($sformatf("post_rst_run_a[%0d]", t), obs_a(), exp_a(t, 8'h00));
    end
    bus_a.run = 1'b0;

    // No dead time: enable stays high, sel advances every 3 cycles.
    step();
    bus_b.run = 1'b1;
    for (int t = 0; t < 30; t++) begin
      step();
      #1;
      check($sformatf("noblank_b[%0d]", t), obs_b(), exp_b(t));
    end
    bus_b.run = 1'b0;
    step();
    #1;
    check("stop_b", obs_b(), 6'b000_000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexed digit-scan controller that drives the 3-to-8 enable decoder directly upstream of it. It steps a 3-bit digit index through the active digits at a programmable slot rate. Between digits it inserts a dead-time window with the enable low so that no two digit lines are ever driven together (anti-ghosting). Its `sel`/`sel_en` outputs connect straight to the decoder's `in`/`en` inputs.

## Interface
- `CLK_DIV`, default 50000: clock cycles per digit slot; legal range is 2 up to 2^20.
- `DIGITS`, default 8: number of active digits, 1..8; the index wraps at `DIGITS-1`.
- `BLANK_CYC`, default 16: dead-time cycles at the end of each slot; legal range is 0 up to `CLK_DIV-1`.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  scan enable; low forces IDLE.
- `mask`  in  8  bit i set means digit i is suppressed (its enable stays low during its slot).
- `sel`  out  3  digit index to the decoder.
- `sel_en`  out  1  decoder enable.
- `slot_start`  out  1  one-cycle pulse on the first ON cycle of every slot.
- `frame_done`  out  1  one-cycle pulse on the first ON cycle of slot 0 after a wrap.

## Operation
- **States:** IDLE, ON, BLANK; register encoding.
- **Reset (async, `rst_n`=0):**
  - state=IDLE, `sel`=0, prescaler=0.
  - `slot_start`=0, `frame_done`=0, hence `sel_en`=0.
- **IDLE:** `sel`=0, prescaler=0. When `run`=1 is sampled, go to ON with prescaler=0 and `slot_start`=1.
- **ON:**
  - Prescaler counts 0..`CLK_DIV-BLANK_CYC-1`.
  - At the terminal count with `BLANK_CYC`>0: go to BLANK.
  - At the terminal count with `BLANK_CYC`=0: stay in ON, advance `sel`, assert `slot_start`.
- **BLANK:** Prescaler continues up to `CLK_DIV-1`. At the terminal count: advance `sel`, go to ON, assert `slot_start`.
- **Index advance:** `sel` goes to `sel+1`, or to 0 when `sel`==`DIGITS-1`. On a wrap, `frame_done` is asserted together with `slot_start`. `frame_done` is never asserted on the first slot after leaving IDLE.
- **`sel_en` decode:** `sel_en` = (state==ON) & ~`mask[sel]`. This is combinational from the state register and the `mask` input, so a mask change takes effect in the same cycle.
- **`sel` stability:** `sel` changes only on the transition into ON, so it is stable throughout every cycle in which `sel_en` can be high.
- **`run` deasserted:** sampled `run`=0 in ON or BLANK sends the block to IDLE on the next edge (`sel`=0, prescaler=0, pulses 0). There is no completion of the current slot.
- **Prescaler width:** $clog2(`CLK_DIV`); the counter never exceeds `CLK_DIV-1`.
- **Out-of-range parameters:** illegal values are rejected by elaboration-time checks.

## Timing
- **`run` to first enable:** 1 cycle (`run` is sampled at edge k; `sel_en` is high from cycle k+1, when not masked).
- **Slot period:** exactly `CLK_DIV` cycles, with ON for `CLK_DIV-BLANK_CYC` cycles and BLANK for `BLANK_CYC` cycles.
- **Frame period:** `DIGITS`×`CLK_DIV` cycles.
- **Pulses:** `slot_start` and `frame_done` are registered and high for exactly one cycle.
- **Dead time:** `sel_en` is low for exactly `BLANK_CYC` cycles before every `sel` change. With `BLANK_CYC`=0, `sel` and `sel_en` stay continuous across the boundary.
- **Reset mid-slot:** all outputs drop immediately (asynchronously). After release, the block restarts from IDLE.
- **`run` toggled 1→0→1 within 2 cycles:** one IDLE cycle, then slot 0 restarts with the full ON window.

## Structure
- **Shared package `scan_pkg`:**
  - State localparams (`ST_IDLE`, `ST_ON`, `ST_BLANK`).
  - Width constant for `sel` (3) and mask width (8).
- **Sub-module `scan_prescaler`:** a free-running modulo counter with synchronous clear, a programmable terminal compare and a `tc` pulse. It is instantiated once; the top-level FSM chooses the compare value (ON-end or slot-end).
- **Integration:** the top level instantiates the FSM and index logic. The decoder is instantiated by the integrating wrapper, not inside this block.

## Test plan
- **Reset and start:** `CLK_DIV`=4, `BLANK_CYC`=1, `DIGITS`=8. Release reset, `run`=1 → `sel` goes 0,0,0,(blank),1,1,1,(blank)… with `sel_en`=1,1,1,0 repeating; `slot_start` pulses every 4 cycles.
- **Wrap:** `DIGITS`=5 → `sel` sequence 0..4 then 0. `frame_done` pulses once every 20 cycles, coincident with the slot-0 `slot_start`, and never on the first slot.
- **Mask:** `mask`=8'b0000_0100 → `sel_en` is low for the whole slot where `sel`=2, and timing is unchanged. Flip `mask[1]` mid-slot 1 → `sel_en` follows in the same cycle.
- **No dead time:** `BLANK_CYC`=0, `CLK_DIV`=3 → `sel_en` is constantly 1; `sel` increments every 3 cycles.
- **Stop:** drop `run` in BLANK of slot 3 → next cycle IDLE with `sel`=0 and `sel_en`=0. Re-raise `run` → slot 0 with a full ON window.
- **Async reset mid-ON:** assert `rst_n`=0 between edges → `sel_en`, `sel` and the pulses go to 0 before the next edge. Release → no activity until `run` is sampled.
